// File: rtl/regfile_sb.sv
// Dual-issue 32x32 register file with a load scoreboard.
// Optional write-to-read bypass: define REGFILE_WBYPASS_EN.
module regfile_sb (
    input  logic        clk,
    input  logic        resetn,
    input  logic        W_master_reg_wen,
    input  logic        W_slave_reg_wen,
    input  logic [4:0]  W_master_reg_waddr,
    input  logic [4:0]  W_slave_reg_waddr,
    input  logic [31:0] W_master_reg_wdata,
    input  logic [31:0] W_slave_reg_wdata,
    input  logic        W_master_is_load,
    input  logic        W_slave_is_load,
    input  logic [4:0]  D_master_rs,
    input  logic [4:0]  D_master_rt,
    input  logic [4:0]  D_slave_rs,
    input  logic [4:0]  D_slave_rt,
    output logic [31:0] D_master_rs_data,
    output logic [31:0] D_master_rt_data,
    output logic [31:0] D_slave_rs_data,
    output logic [31:0] D_slave_rt_data,
    input  logic        E_master_load_issue,
    input  logic        E_slave_load_issue,
    input  logic [4:0]  E_master_load_dst,
    input  logic [4:0]  E_slave_load_dst,
    input  logic        flush,
    output logic        D_load_stall
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic [31:0] clr;
    logic [31:0] set;
    logic [31:0] pend_vis;
    logic [4:0]  raddr [4];
    logic [31:0] rdata [4];

    assign raddr[0] = D_master_rs;
    assign raddr[1] = D_master_rt;
    assign raddr[2] = D_slave_rs;
    assign raddr[3] = D_slave_rt;

    assign D_master_rs_data = rdata[0];
    assign D_master_rt_data = rdata[1];
    assign D_slave_rs_data  = rdata[2];
    assign D_slave_rt_data  = rdata[3];

    // Next array contents; slave is applied last so it wins a shared address.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (W_master_reg_wen && W_master_reg_waddr != 5'd0) begin
            regs_d[W_master_reg_waddr] = W_master_reg_wdata;
        end
        if (W_slave_reg_wen && W_slave_reg_waddr != 5'd0) begin
            regs_d[W_slave_reg_waddr] = W_slave_reg_wdata;
        end
        regs_d[0] = '0;
    end

    // Scoreboard update: clears first, younger issues override, flush wins all.
    always_comb begin
        clr = '0;
        set = '0;
        if (W_master_reg_wen && W_master_is_load) begin
            clr[W_master_reg_waddr] = 1'b1;
        end
        if (W_slave_reg_wen && W_slave_is_load) begin
            clr[W_slave_reg_waddr] = 1'b1;
        end
        if (E_master_load_issue) begin
            set[E_master_load_dst] = 1'b1;
        end
        if (E_slave_load_issue) begin
            set[E_slave_load_dst] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | set;
        if (flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    // Combinational read ports, r0 hardwired to zero.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = regs_q[raddr[p]];
`ifdef REGFILE_WBYPASS_EN
            if (W_master_reg_wen && W_master_reg_waddr == raddr[p]) begin
                rdata[p] = W_master_reg_wdata;
            end
            if (W_slave_reg_wen && W_slave_reg_waddr == raddr[p]) begin
                rdata[p] = W_slave_reg_wdata;
            end
`endif
            if (raddr[p] == 5'd0) begin
                rdata[p] = '0;
            end
        end
    end

    // Stall when any nonzero source still waits on its load.
    always_comb begin
`ifdef REGFILE_WBYPASS_EN
        pend_vis = pend_q & ~clr;
`else
        pend_vis = pend_q;
`endif
        D_load_stall = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (raddr[p] != 5'd0 && pend_vis[raddr[p]]) begin
                D_load_stall = 1'b1;
            end
        end
    end

    // Array and scoreboard state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb.
// Honours REGFILE_WBYPASS_EN in its expected values.
module tb_regfile_sb;

`ifdef REGFILE_WBYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        mwen, swen, mld, sld;
    logic [4:0]  mwa, swa;
    logic [31:0] mwd, swd;
    logic [4:0]  mrs, mrt, srs, srt;
    logic [31:0] mrs_d, mrt_d, srs_d, srt_d;
    logic        mli, sli, flush;
    logic [4:0]  mdst, sdst;
    logic        stall;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk                (clk),
        .resetn             (resetn),
        .W_master_reg_wen   (mwen),
        .W_slave_reg_wen    (swen),
        .W_master_reg_waddr (mwa),
        .W_slave_reg_waddr  (swa),
        .W_master_reg_wdata (mwd),
        .W_slave_reg_wdata  (swd),
        .W_master_is_load   (mld),
        .W_slave_is_load    (sld),
        .D_master_rs        (mrs),
        .D_master_rt        (mrt),
        .D_slave_rs         (srs),
        .D_slave_rt         (srt),
        .D_master_rs_data   (mrs_d),
        .D_master_rt_data   (mrt_d),
        .D_slave_rs_data    (srs_d),
        .D_slave_rt_data    (srt_d),
        .E_master_load_issue(mli),
        .E_slave_load_issue (sli),
        .E_master_load_dst  (mdst),
        .E_slave_load_dst   (sdst),
        .flush              (flush),
        .D_load_stall       (stall)
    );

    typedef struct {
        string            name;
        logic             rstn;
        logic             mwen, swen, mld, sld;
        logic [4:0]       mwa, swa;
        logic [31:0]      mwd, swd;
        logic [3:0][4:0]  ra;
        logic             mli, sli, flush;
        logic [4:0]       mdst, sdst;
        logic [3:0][31:0] ed;
        logic             es;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t idle(string n);
        vec_t v;
        v.name = n;
        v.rstn = 1'b1;
        v.mwen = 1'b0; v.swen = 1'b0;
        v.mld = 1'b0;  v.sld = 1'b0;
        v.mwa = '0;    v.swa = '0;
        v.mwd = '0;    v.swd = '0;
        v.ra = '0;
        v.mli = 1'b0;  v.sli = 1'b0;
        v.flush = 1'b0;
        v.mdst = '0;   v.sdst = '0;
        v.ed = '0;
        v.es = 1'b0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        resetn = v.rstn;
        mwen = v.mwen; swen = v.swen;
        mld = v.mld;   sld = v.sld;
        mwa = v.mwa;   swa = v.swa;
        mwd = v.mwd;   swd = v.swd;
        mrs = v.ra[0]; mrt = v.ra[1];
        srs = v.ra[2]; srt = v.ra[3];
        mli = v.mli;   sli = v.sli;
        flush = v.flush;
        mdst = v.mdst; sdst = v.sdst;
    endtask

    task automatic check(input vec_t v);
        logic [3:0][31:0] act;
        act[0] = mrs_d; act[1] = mrt_d;
        act[2] = srs_d; act[3] = srt_d;
        vectors++;
        for (int p = 0; p < 4; p++) begin
            if (act[p] !== v.ed[p]) begin
                miscompares++;
                $display("FAIL %s port%0d r%0d: got %h want %h",
                         v.name, p, v.ra[p], act[p], v.ed[p]);
            end
        end
        if (stall !== v.es) begin
            miscompares++;
            $display("FAIL %s stall: got %b want %b", v.name, stall, v.es);
        end
    endtask

    initial begin
        vec_t v;
        v = idle("rst0"); v.rstn = 1'b0; tbl.push_back(v);
        v = idle("rst1"); v.rstn = 1'b0; tbl.push_back(v);
        for (int k = 0; k < 8; k++) begin
            v = idle("rd_after_rst");
            for (int p = 0; p < 4; p++) begin
                v.ra[p] = (4 * k + p + 1 > 31) ? 5'd0 : 5'(4 * k + p + 1);
            end
            tbl.push_back(v);
        end
        v = idle("wconf");
        v.mwen = 1; v.mwa = 5; v.mwd = 32'h11111111;
        v.swen = 1; v.swa = 5; v.swd = 32'h22222222;
        v.ra[0] = 5; v.ed[0] = BYP ? 32'h22222222 : 32'h0;
        tbl.push_back(v);
        v = idle("wr_r0");
        v.mwen = 1; v.mwa = 0; v.mwd = 32'hFFFFFFFF;
        v.ra[0] = 5; v.ed[0] = 32'h22222222;
        v.ra[1] = 0; v.ed[1] = 32'h0;
        tbl.push_back(v);
        v = idle("rd_r0_r5");
        v.ra[1] = 0; v.ra[3] = 5; v.ed[3] = 32'h22222222;
        v.swen = 1; v.swa = 6; v.swd = 32'h0000600D;
        v.mwen = 1; v.mwa = 10; v.mwd = 32'h0000000A;
        tbl.push_back(v);
        v = idle("rd_r6_r10");
        v.ra[0] = 6; v.ed[0] = 32'h0000600D;
        v.ra[2] = 10; v.ed[2] = 32'h0000000A;
        tbl.push_back(v);
        v = idle("issue_r8");
        v.mli = 1; v.mdst = 8; v.ra[3] = 8;
        tbl.push_back(v);
        v = idle("wait_r8"); v.ra[3] = 8; v.es = 1; tbl.push_back(v);
        v = idle("clr_r8");
        v.mwen = 1; v.mwa = 8; v.mwd = 32'h0000ABCD; v.mld = 1;
        v.ra[3] = 8; v.ed[3] = BYP ? 32'h0000ABCD : 32'h0;
        v.es = !BYP;
        tbl.push_back(v);
        v = idle("after_r8");
        v.ra[3] = 8; v.ed[3] = 32'h0000ABCD;
        tbl.push_back(v);
        v = idle("issue_r3"); v.sli = 1; v.sdst = 3; tbl.push_back(v);
        v = idle("setclr_r3");
        v.mwen = 1; v.mwa = 3; v.mwd = 32'h33; v.mld = 1;
        v.sli = 1; v.sdst = 3;
        v.ra[2] = 3; v.ed[2] = BYP ? 32'h33 : 32'h0; v.es = !BYP;
        tbl.push_back(v);
        v = idle("still_r3");
        v.ra[2] = 3; v.ed[2] = 32'h33; v.es = 1;
        tbl.push_back(v);
        v = idle("flush_r4");
        v.flush = 1; v.mli = 1; v.mdst = 4;
        v.ra[2] = 3; v.ed[2] = 32'h33; v.es = 1;
        tbl.push_back(v);
        v = idle("after_flush");
        v.ra[0] = 4; v.ra[2] = 3; v.ed[2] = 32'h33;
        tbl.push_back(v);
        v = idle("dual_r12");
        v.mli = 1; v.mdst = 12; v.sli = 1; v.sdst = 12;
        tbl.push_back(v);
        v = idle("wait_r12"); v.ra[1] = 12; v.es = 1; tbl.push_back(v);
        v = idle("sclr_r12");
        v.swen = 1; v.swa = 12; v.swd = 32'hC; v.sld = 1;
        v.mli = 1; v.mdst = 13;
        tbl.push_back(v);
        v = idle("after_r12");
        v.ra[1] = 12; v.ed[1] = 32'hC;
        v.mwen = 1; v.mwa = 13; v.mwd = 32'hD;
        tbl.push_back(v);
        v = idle("alu_no_clr");
        v.ra[0] = 13; v.ed[0] = 32'hD; v.es = 1;
        v.mwen = 1; v.mwa = 9; v.mwd = 32'h1;
        v.flush = 1;
        tbl.push_back(v);
        v = idle("byp_r9");
        v.mwen = 1; v.mwa = 9; v.mwd = 32'h5A5A5A5A;
        v.ra[0] = 9; v.ed[0] = BYP ? 32'h5A5A5A5A : 32'h1;
        tbl.push_back(v);
        v = idle("rd_r9");
        v.ra[0] = 9; v.ed[0] = 32'h5A5A5A5A;
        v.sli = 1; v.sdst = 14;
        tbl.push_back(v);
        v = idle("rst_wr_r7");
        v.rstn = 0; v.mwen = 1; v.mwa = 7; v.mwd = 32'h1234;
        v.ra[0] = 9; v.ed[0] = 32'h5A5A5A5A; v.ra[1] = 14; v.es = 1;
        tbl.push_back(v);
        v = idle("after_rst");
        v.ra[0] = 7; v.ra[1] = 5; v.ra[2] = 9; v.ra[3] = 14;
        tbl.push_back(v);

        drive(idle("init"));
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check(tbl[i]);
        end
        @(negedge clk);
        drive(idle("end"));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
